// File: rtl/bcd8_formatter.sv
// ---------------------------------------------------------------------------
// bcd8_formatter
//   Converts a signed two's-complement value into the digit word and
//   decimal-point mask used by the 8-digit seven-segment driver.
//   The value is first made positive, then an iterative double-dabble engine
//   turns it into BCD, one shift per cycle.
//   The display word is then formatted with:
//     - leading-zero blanking,
//     - a minus sign,
//     - a forced "0." when fractional digits are requested,
//     - an overflow pattern when a negative number leaves no room for '-'.
//   Outputs hold between conversions, so the driver can scan them at any time.
//
// Ports
//   i_clk      system clock
//   i_rst      synchronous, active-high reset
//   i_start    one-cycle conversion request (sampled only when idle)
//   i_value    signed value to display (W bits)
//   i_frac     number of fractional digits, 0..7 (sampled with i_start)
//   o_busy     conversion in progress
//   o_done     one-cycle pulse when new outputs are valid
//   o_bcd8d    digit codes, [31:28] = leftmost digit; 4'hA '-', 4'hB blank
//   o_dp_mask  decimal-point enables, bit 0 = leftmost digit
//   o_ovf      last conversion did not fit
// ---------------------------------------------------------------------------
module bcd8_formatter #(
   parameter int W = 24
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [W-1:0] i_value,
   input  logic [2:0]   i_frac,
   output logic         o_busy,
   output logic         o_done,
   output logic [31:0]  o_bcd8d,
   output logic [7:0]   o_dp_mask,
   output logic         o_ovf
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ABS    = 2'd1,
      ST_SHIFT  = 2'd2,
      ST_FORMAT = 2'd3
   } state_t;

   localparam logic [4:0] LAST_SHIFT = 5'(W - 1);

   state_t        state_r;
   state_t        state_s;
   logic [W-1:0]  value_r;
   logic [2:0]    frac_r;
   logic          sign_r;
   logic [W-1:0]  mag_r;
   logic [31:0]   scratch_r;
   logic [4:0]    count_r;

   logic [31:0]   adj_s;
   logic [2:0]    hi_s;
   logic [2:0]    msd_s;
   logic          ovf_s;
   logic [31:0]   word_s;
   logic [7:0]    dp_s;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic: IDLE -> ABS -> SHIFT (W cycles) -> FORMAT -> IDLE
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (i_start) begin
               state_s = ST_ABS;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ABS: begin
            state_s = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (count_r == LAST_SHIFT) begin
               state_s = ST_FORMAT;
            end else begin
               state_s = ST_SHIFT;
            end
         end
         ST_FORMAT: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Double-dabble correction: add 3 to every BCD nibble of 5 or more
   always_comb begin
      adj_s = scratch_r;
      for (int j = 0; j < 8; j++) begin
         if (scratch_r[4*j +: 4] >= 4'd5) begin
            adj_s[4*j +: 4] = scratch_r[4*j +: 4] + 4'd3;
         end else begin
            adj_s[4*j +: 4] = scratch_r[4*j +: 4];
         end
      end
   end

   // Display formatting from the finished BCD scratch
   always_comb begin
      hi_s   = 3'd0;
      msd_s  = 3'd0;
      ovf_s  = 1'b0;
      word_s = 32'hBBBB_BBBB;
      dp_s   = 8'h00;

      // Highest nonzero digit; an all-zero value leaves it at 0
      for (int j = 0; j < 8; j++) begin
         if (scratch_r[4*j +: 4] != 4'd0) begin
            hi_s = 3'(j);
         end else begin
            hi_s = hi_s;
         end
      end

      // The fractional digit count forces "0.xx" digits to be shown
      if (hi_s > frac_r) begin
         msd_s = hi_s;
      end else begin
         msd_s = frac_r;
      end

      for (int j = 0; j < 8; j++) begin
         if (3'(j) <= msd_s) begin
            word_s[4*j +: 4] = scratch_r[4*j +: 4];
         end else if (sign_r && (3'(j) == (msd_s + 3'd1))) begin
            word_s[4*j +: 4] = 4'hA;
         end else begin
            word_s[4*j +: 4] = 4'hB;
         end
      end

      // Mask bit 0 is the leftmost digit, so digit F maps to bit 7-F
      if (frac_r != 3'd0) begin
         dp_s = 8'h80 >> frac_r;
      end else begin
         dp_s = 8'h00;
      end

      // A negative value using all eight digits has nowhere to put '-'
      if (sign_r && (msd_s == 3'd7)) begin
         ovf_s  = 1'b1;
         word_s = 32'hAAAA_AAAA;
         dp_s   = 8'h00;
      end else begin
         ovf_s  = 1'b0;
      end
   end

   // Datapath: capture, absolute value, shift engine
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         value_r   <= '0;
         frac_r    <= 3'd0;
         sign_r    <= 1'b0;
         mag_r     <= '0;
         scratch_r <= 32'h0000_0000;
         count_r   <= 5'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (i_start) begin
                  value_r <= i_value;
                  frac_r  <= i_frac;
               end
            end
            ST_ABS: begin
               sign_r <= value_r[W-1];
               // Negating the most negative value wraps to 2^(W-1), which is
               // the correct magnitude when read as unsigned.
               if (value_r[W-1]) begin
                  mag_r <= ~value_r + {{(W-1){1'b0}}, 1'b1};
               end else begin
                  mag_r <= value_r;
               end
               scratch_r <= 32'h0000_0000;
               count_r   <= 5'd0;
            end
            ST_SHIFT: begin
               scratch_r <= {adj_s[30:0], mag_r[W-1]};
               mag_r     <= {mag_r[W-2:0], 1'b0};
               count_r   <= count_r + 5'd1;
            end
            default: begin
            end
         endcase
      end
   end

   // Registered outputs; the display outputs change only at the FORMAT edge
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_bcd8d   <= 32'hBBBB_BBB0;
         o_dp_mask <= 8'h00;
         o_ovf     <= 1'b0;
      end else begin
         o_busy <= (state_s != ST_IDLE);
         if (state_r == ST_FORMAT) begin
            o_done    <= 1'b1;
            o_bcd8d   <= word_s;
            o_dp_mask <= dp_s;
            o_ovf     <= ovf_s;
         end else begin
            o_done    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bcd8_formatter.sv
// ---------------------------------------------------------------------------
// tb_bcd8_formatter
//   Scoreboard bench for bcd8_formatter with two instances (W=24 and W=27).
//   Stimulus pushes the expected display into a per-instance queue; a monitor
//   pops and compares on every o_done and checks that outputs hold otherwise.
// ---------------------------------------------------------------------------
module tb_bcd8_formatter;

   typedef struct packed {
      logic [31:0] bcd;
      logic [7:0]  dp;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst_q = 1'b0;
   logic        mon_en = 1'b0;

   logic        start24 = 1'b0;
   logic [23:0] val24 = '0;
   logic [2:0]  frac24 = 3'd0;
   logic        busy24, done24, ovf24;
   logic [31:0] bcd24;
   logic [7:0]  dp24;

   logic        start27 = 1'b0;
   logic [26:0] val27 = '0;
   logic [2:0]  frac27 = 3'd0;
   logic        busy27, done27, ovf27;
   logic [31:0] bcd27;
   logic [7:0]  dp27;

   exp_t q24[$];
   exp_t q27[$];
   exp_t hold [2];

   int checks = 0;
   int failures = 0;

   bcd8_formatter #(.W(24)) dut24 (
      .i_clk(clk), .i_rst(rst), .i_start(start24), .i_value(val24), .i_frac(frac24),
      .o_busy(busy24), .o_done(done24), .o_bcd8d(bcd24), .o_dp_mask(dp24), .o_ovf(ovf24)
   );

   bcd8_formatter #(.W(27)) dut27 (
      .i_clk(clk), .i_rst(rst), .i_start(start27), .i_value(val27), .i_frac(frac27),
      .o_busy(busy27), .o_done(done27), .o_bcd8d(bcd27), .o_dp_mask(dp27), .o_ovf(ovf27)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rst_q <= rst;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout expected=event", name);
   endtask

   // Reference display from decimal arithmetic on the signed value
   function automatic exp_t model(input longint v, input int f);
      exp_t   r;
      longint mag;
      int     d[8];
      int     hi;
      int     m;
      int     nib;
      mag = (v < 0) ? -v : v;
      hi  = 0;
      for (int j = 0; j < 8; j++) begin
         d[j] = int'(mag % 10);
         mag  = mag / 10;
         if (d[j] != 0) hi = j;
      end
      m     = (hi > f) ? hi : f;
      r.bcd = 32'h0;
      r.dp  = (f > 0) ? 8'(1 << (7 - f)) : 8'h00;
      r.ovf = 1'b0;
      for (int j = 0; j < 8; j++) begin
         if (j <= m) nib = d[j];
         else if (v < 0 && j == m + 1) nib = 10;
         else nib = 11;
         r.bcd[4*j +: 4] = 4'(nib);
      end
      if (v < 0 && m == 7) begin
         r.bcd = 32'hAAAA_AAAA;
         r.dp  = 8'h00;
         r.ovf = 1'b1;
      end
      return r;
   endfunction

   // Monitor step for one instance, called on the falling edge
   task automatic observe(input int sel, input logic busy, input logic done,
                          input logic [31:0] bcd, input logic [7:0] dp, input logic ovf);
      exp_t e;
      string tag;
      tag = (sel == 0) ? "w24" : "w27";
      if (rst_q) begin
         check({tag, "_rst_busy"}, 64'(busy), 64'd0);
         check({tag, "_rst_done"}, 64'(done), 64'd0);
         check({tag, "_rst_bcd"}, 64'(bcd), 64'hBBBB_BBB0);
         check({tag, "_rst_dp"}, 64'(dp), 64'h00);
         check({tag, "_rst_ovf"}, 64'(ovf), 64'd0);
         hold[sel] = '{bcd: 32'hBBBB_BBB0, dp: 8'h00, ovf: 1'b0};
      end else if (done) begin
         if ((sel == 0 && q24.size() == 0) || (sel == 1 && q27.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected_done actual=done expected=no_done", tag);
         end else begin
            e = (sel == 0) ? q24.pop_front() : q27.pop_front();
            check({tag, "_bcd"}, 64'(bcd), 64'(e.bcd));
            check({tag, "_dp"}, 64'(dp), 64'(e.dp));
            check({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
            hold[sel] = e;
         end
      end else begin
         check({tag, "_hold"}, 64'({bcd, dp, ovf}), 64'(hold[sel]));
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            observe(0, busy24, done24, bcd24, dp24, ovf24);
            observe(1, busy27, done27, bcd27, dp27, ovf27);
         end
      end
   end

   // Issue one start (waits for idle), pushing its expected result
   task automatic launch(input int sel, input longint v, input int f);
      int n;
      n = 0;
      while (((sel == 0) ? busy24 : busy27) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) timeout_fail("launch_idle");
      if (sel == 0) begin
         start24 = 1'b1;
         val24   = v[23:0];
         frac24  = 3'(f);
         q24.push_back(model(v, f));
      end else begin
         start27 = 1'b1;
         val27   = v[26:0];
         frac27  = 3'(f);
         q27.push_back(model(v, f));
      end
      @(posedge clk);
      #1;
      start24 = 1'b0;
      start27 = 1'b0;
   endtask

   task automatic drain(input int sel);
      int n;
      n = 0;
      while (((sel == 0) ? q24.size() : q27.size()) != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) timeout_fail("drain");
   endtask

   initial begin
      longint v;
      #100000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      longint v;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Latency and busy window for W=24
      launch(0, 1234, 0);
      check("busy_cycle1", 64'(busy24), 64'd1);
      for (int e = 1; e <= 25; e++) begin
         @(posedge clk);
         #1;
         check("busy_window", 64'({busy24, done24}), 64'b10);
      end
      @(posedge clk);
      #1;
      check("done_edge26", 64'({busy24, done24}), 64'b01);
      @(posedge clk);
      #1;
      check("done_one_cycle", 64'(done24), 64'd0);

      launch(0, -1234, 2);
      launch(0, 5, 3);
      launch(0, 0, 0);
      launch(0, -8388608, 0);
      launch(0, 8388607, 7);
      drain(0);

      launch(1, 67108863, 0);
      launch(1, -10000000, 0);
      launch(1, -1, 7);
      launch(1, -9999999, 0);
      launch(1, -67108864, 0);
      drain(1);

      // Second start while busy is ignored
      launch(0, 4321, 1);
      repeat (9) @(posedge clk);
      #1;
      start24 = 1'b1;
      val24   = 24'd999;
      frac24  = 3'd0;
      @(posedge clk);
      #1;
      start24 = 1'b0;
      drain(0);
      repeat (30) @(posedge clk);
      #1;

      // Reset mid-conversion aborts without a done
      launch(0, 777777, 1);
      repeat (11) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q24.delete();
      repeat (30) @(posedge clk);
      #1;
      launch(0, -42, 0);
      drain(0);

      // Randomized back-to-back traffic on both widths
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 2) == 0)
            v = longint'($urandom_range(0, 2000)) - 64'sd1000;
         else
            v = longint'($urandom_range(0, 32'hFF_FFFF)) - 64'sd8388608;
         launch(0, v, int'($urandom_range(0, 7)));
      end
      drain(0);
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 2) == 0)
            v = longint'($urandom_range(0, 2000)) - 64'sd1000;
         else
            v = longint'($urandom_range(0, 32'h7FF_FFFF)) - 64'sd67108864;
         launch(1, v, int'($urandom_range(0, 7)));
      end
      drain(1);
      repeat (5) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
